// File: rtl/core6_mem_arbiter.sv
// core6_mem_arbiter: two-master round-robin arbiter in front of a single-port
// on-chip memory. Optional bus lock enabled by defining CORE6_ARB_LOCK_EN.
module core6_mem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
`ifdef CORE6_ARB_LOCK_EN
    input  logic              m0_lock,
`endif
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
`ifdef CORE6_ARB_LOCK_EN
    input  logic              m1_lock,
`endif
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic [BE_W-1:0]   s_byteenable,
    output logic              s_chipselect,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic              s_clken,
    input  logic [DATA_W-1:0] s_readdata
);

    logic              w_req0;
    logic              w_req1;
    logic              w_rr0;
    logic              w_rr1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any;
    logic              w_rd_push;
    logic              r_last_grant;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [RD_LAT-1:0] r_pipe_id;

`ifdef CORE6_ARB_LOCK_EN
    logic              r_own_vld;
    logic              r_own_id;
    logic              w_gnt_lock;
`endif

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // Round-robin pick: on contention the master not granted last time wins
    always_comb begin
        w_rr0 = w_req0 & (~w_req1 | r_last_grant);
        w_rr1 = w_req1 & (~w_req0 | ~r_last_grant);
    end

`ifdef CORE6_ARB_LOCK_EN
    // A valid owner excludes the other master; grants are blocked in reset
    always_comb begin
        if (r_own_vld) begin
            w_gnt0 = reset_n & w_req0 & ~r_own_id;
            w_gnt1 = reset_n & w_req1 & r_own_id;
        end else begin
            w_gnt0 = reset_n & w_rr0;
            w_gnt1 = reset_n & w_rr1;
        end
    end

    assign w_gnt_lock = w_gnt1 ? m1_lock : (w_gnt0 & m0_lock);
`else
    // Grants are blocked while reset is held
    always_comb begin
        w_gnt0 = reset_n & w_rr0;
        w_gnt1 = reset_n & w_rr1;
    end
`endif

    assign w_any = w_gnt0 | w_gnt1;

    // Slave-side mux follows the granted master
    always_comb begin
        s_address    = w_gnt1 ? m1_address    : m0_address;
        s_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
        s_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
        s_write      = w_gnt1 ? m1_write      : (w_gnt0 & m0_write);
        s_chipselect = w_any;
    end

    assign s_clken = 1'b1;

    assign m0_waitrequest = w_req0 & ~w_gnt0;
    assign m1_waitrequest = w_req1 & ~w_gnt1;

    // Read with write asserted is a write: it never enters the read pipe
    assign w_rd_push = (w_gnt0 & m0_read & ~m0_write)
                     | (w_gnt1 & m1_read & ~m1_write);

    // Fairness state: remember who won the last granted cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
        end else if (w_any) begin
            r_last_grant <= w_gnt1;
        end
    end

    // Read-tag pipe matching the memory latency; reset drops reads in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_push;
            r_pipe_id[0]  <= w_gnt1;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
        end
    end

`ifdef CORE6_ARB_LOCK_EN
    // Owner is claimed by a locked grant, released by its first unlocked one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_own_vld <= 1'b0;
            r_own_id  <= 1'b0;
        end else if (w_any) begin
            if (w_gnt_lock) begin
                r_own_vld <= 1'b1;
                r_own_id  <= w_gnt1;
            end else begin
                r_own_vld <= 1'b0;
            end
        end
    end
`endif

    assign m0_readdatavalid = r_pipe_vld[RD_LAT-1] & ~r_pipe_id[RD_LAT-1];
    assign m1_readdatavalid = r_pipe_vld[RD_LAT-1] & r_pipe_id[RD_LAT-1];
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

endmodule

// File: tb/tb_core6_mem_arbiter.sv
// tb_core6_mem_arbiter: table vectors, directed corner sequences and a
// randomized phase against a transaction-level reference model.
module tb_core6_mem_arbiter;

    localparam int AW     = 13;
    localparam int DW     = 32;
    localparam int BW     = 4;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] m0_address, m1_address;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] s_address;
    logic [BW-1:0] s_byteenable;
    logic          s_chipselect, s_write, s_clken;
    logic [DW-1:0] s_writedata, s_readdata;
`ifdef CORE6_ARB_LOCK_EN
    logic          m0_lock = 1'b0;
    logic          m1_lock = 1'b0;
`endif

    core6_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata),
`ifdef CORE6_ARB_LOCK_EN
        .m0_lock(m0_lock),
`endif
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata),
`ifdef CORE6_ARB_LOCK_EN
        .m1_lock(m1_lock),
`endif
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_byteenable(s_byteenable),
        .s_chipselect(s_chipselect), .s_write(s_write),
        .s_writedata(s_writedata), .s_clken(s_clken),
        .s_readdata(s_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initval(input int a);
        if (a == 5)    return 32'hDEADBEEF;
        if (a == 8191) return 32'h12345678;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Behavioural single-port memory on the slave side
    logic [31:0] mem [0:8191];
    logic [31:0] rpipe [RD_LAT];
    bit          mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int a = 0; a < 8192; a++) mem[a] <= initval(a);
            mem_init <= 1'b1;
        end else if (s_chipselect) begin
            if (s_write) begin
                for (int b = 0; b < 4; b++)
                    if (s_byteenable[b])
                        mem[s_address][8*b +: 8] <= s_writedata[8*b +: 8];
            end else begin
                rpipe[0] <= mem[s_address];
            end
        end
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    assign s_readdata = rpipe[RD_LAT-1];

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] shadow [0:8191];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input int a0,
                         input logic [3:0] be0, input logic [31:0] d0,
                         input logic r1, input logic w1, input int a1,
                         input logic [3:0] be1, input logic [31:0] d1);
        m0_read = r0; m0_write = w0; m0_address = a0[12:0];
        m0_byteenable = be0; m0_writedata = d0;
        m1_read = r1; m1_write = w1; m1_address = a1[12:0];
        m1_byteenable = be1; m1_writedata = d1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0);
    endtask

    task automatic sh_write(input int a, input logic [3:0] be,
                            input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        idle();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic r0, w0, r1, w1;
        int   g;
        logic wr0, wr1, cs, sw, rdv0, rdv1;
    } vec_t;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } rd_t;

    vec_t tbl [9];
    rd_t  q [$];

    logic        rq_r  [2];
    logic        rq_w  [2];
    int          rq_a  [2];
    logic [3:0]  rq_be [2];
    logic [31:0] rq_d  [2];
    bit          stall [2];

    initial begin
        int last;
        int g;
        int prev;
        logic e0, e1;

        for (int a = 0; a < 8192; a++) shadow[a] = initval(a);
        idle();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state: requester stalled, no slave access
        m0_read = 1'b1;
        #1;
        chk("rst_wait0", m0_waitrequest, 1);
        chk("rst_cs", s_chipselect, 0);
        chk("rst_sw", s_write, 0);
        chk("rst_rdv0", m0_readdatavalid, 0);
        chk("rst_rdv1", m1_readdatavalid, 0);
        reset_n = 1'b1;
        #1;
        chk("rel_wait0", m0_waitrequest, 0);
        chk("rel_cs", s_chipselect, 1);
        @(negedge clk);
        idle();
        #1;
        chk("rel_rdv0", m0_readdatavalid, 1);
        chk("rel_data", m0_readdata, shadow[0]);

        // Lone read of 0x0005
        @(negedge clk);
        drive(1, 0, 5, 4'hF, 0, 0, 0, 0, 4'h0, 0);
        #1;
        chk("lone_wait0", m0_waitrequest, 0);
        @(negedge clk);
        idle();
        #1;
        chk("lone_rdv0", m0_readdatavalid, 1);
        chk("lone_data", m0_readdata, 32'hDEADBEEF);
        chk("lone_rdv1", m1_readdatavalid, 0);

        // Byte write at top address, then read back
        @(negedge clk);
        drive(0, 0, 0, 4'h0, 0, 0, 1, 13'h1FFF, 4'b0001, 32'h000000AA);
        #1;
        chk("bw_addr", s_address, 13'h1FFF);
        chk("bw_sw", s_write, 1);
        chk("bw_be", s_byteenable, 4'b0001);
        chk("bw_wait1", m1_waitrequest, 0);
        sh_write(8191, 4'b0001, 32'h000000AA);
        @(negedge clk);
        drive(0, 0, 0, 4'h0, 0, 1, 0, 13'h1FFF, 4'hF, 0);
        #1;
        chk("br_wait1", m1_waitrequest, 0);
        @(negedge clk);
        idle();
        #1;
        chk("br_rdv1", m1_readdatavalid, 1);
        chk("br_data", m1_readdata, 32'h123456AA);
        chk("br_rdv0", m0_readdatavalid, 0);

        // Table vectors from a fresh reset
        tbl[0] = '{1,0,0,0, 0, 0,0,1,0, 0,0};
        tbl[1] = '{1,0,1,0, 1, 1,0,1,0, 1,0};
        tbl[2] = '{1,0,1,0, 0, 0,1,1,0, 0,1};
        tbl[3] = '{0,0,0,1, 1, 0,0,1,1, 1,0};
        tbl[4] = '{0,0,0,0, 2, 0,0,0,0, 0,0};
        tbl[5] = '{0,1,1,0, 0, 0,1,1,1, 0,0};
        tbl[6] = '{1,1,0,0, 0, 0,0,1,1, 0,0};
        tbl[7] = '{0,0,1,0, 1, 0,0,1,0, 0,0};
        tbl[8] = '{0,0,0,0, 2, 0,0,0,0, 0,1};
        reset_pulse();
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].r0, tbl[i].w0, 'h100 + i, 4'hF, 32'hA0000000 + i,
                  tbl[i].r1, tbl[i].w1, 'h200 + i, 4'hF, 32'hB0000000 + i);
            #1;
            chk($sformatf("tbl%0d_wait0", i), m0_waitrequest, tbl[i].wr0);
            chk($sformatf("tbl%0d_wait1", i), m1_waitrequest, tbl[i].wr1);
            chk($sformatf("tbl%0d_cs", i), s_chipselect, tbl[i].cs);
            chk($sformatf("tbl%0d_sw", i), s_write, tbl[i].sw);
            chk($sformatf("tbl%0d_rdv0", i), m0_readdatavalid, tbl[i].rdv0);
            chk($sformatf("tbl%0d_rdv1", i), m1_readdatavalid, tbl[i].rdv1);
            if (tbl[i].g != 2) begin
                chk($sformatf("tbl%0d_addr", i), s_address,
                    (tbl[i].g == 1) ? 'h200 + i : 'h100 + i);
                if (tbl[i].sw) begin
                    chk($sformatf("tbl%0d_wd", i), s_writedata,
                        (tbl[i].g == 1) ? 32'hB0000000 + i
                                        : 32'hA0000000 + i);
                    sh_write((tbl[i].g == 1) ? 'h200 + i : 'h100 + i, 4'hF,
                             (tbl[i].g == 1) ? 32'hB0000000 + i
                                             : 32'hA0000000 + i);
                end
            end
            @(negedge clk);
        end

        // Contention: both read for 6 cycles, last grant was m1
        prev = -1;
        for (int k = 0; k < 7; k++) begin
            if (k < 6) drive(1, 0, 'h10, 4'hF, 0, 1, 0, 'h20, 4'hF, 0);
            else idle();
            #1;
            if (k < 6) begin
                chk($sformatf("ct%0d_wait0", k), m0_waitrequest, k % 2);
                chk($sformatf("ct%0d_wait1", k), m1_waitrequest, 1 - k % 2);
            end
            if (prev >= 0) begin
                chk($sformatf("ct%0d_rdv0", k), m0_readdatavalid, prev == 0);
                chk($sformatf("ct%0d_rdv1", k), m1_readdatavalid, prev == 1);
                chk($sformatf("ct%0d_data", k), m0_readdata,
                    shadow[(prev == 0) ? 'h10 : 'h20]);
            end
            prev = (k < 6) ? k % 2 : -1;
            @(negedge clk);
        end

        // Reset in the cycle after a read grant drops the read
        drive(1, 0, 7, 4'hF, 0, 0, 0, 0, 4'h0, 0);
        #1;
        chk("mr_wait0", m0_waitrequest, 0);
        @(negedge clk);
        idle();
        reset_n = 1'b0;
        #1;
        chk("mr_rdv0_rst", m0_readdatavalid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("mr_rdv0_rel", m0_readdatavalid, 0);
        chk("mr_rdv1_rel", m1_readdatavalid, 0);
        @(negedge clk);
        drive(1, 0, 8, 4'hF, 0, 1, 0, 9, 4'hF, 0);
        #1;
        chk("mr_last_wait0", m0_waitrequest, 0);
        chk("mr_last_wait1", m1_waitrequest, 1);
        @(negedge clk);
        idle();

`ifdef CORE6_ARB_LOCK_EN
        // m0 locked read then unlocked write; m1 waits for both
        reset_pulse();
        drive(1, 0, 'h30, 4'hF, 0, 1, 0, 'h31, 4'hF, 0);
        m0_lock = 1'b1;
        #1;
        chk("lk_a_wait0", m0_waitrequest, 0);
        chk("lk_a_wait1", m1_waitrequest, 1);
        @(negedge clk);
        drive(0, 1, 'h30, 4'hF, 32'hC0FFEE00, 1, 0, 'h31, 4'hF, 0);
        m0_lock = 1'b0;
        #1;
        chk("lk_b_wait0", m0_waitrequest, 0);
        chk("lk_b_wait1", m1_waitrequest, 1);
        chk("lk_b_sw", s_write, 1);
        chk("lk_b_rdv0", m0_readdatavalid, 1);
        sh_write('h30, 4'hF, 32'hC0FFEE00);
        @(negedge clk);
        drive(0, 0, 0, 4'h0, 0, 1, 0, 'h31, 4'hF, 0);
        #1;
        chk("lk_c_wait1", m1_waitrequest, 0);
        chk("lk_c_cs", s_chipselect, 1);
        @(negedge clk);
        idle();
`endif

        // Randomized phase against the transaction model
        reset_pulse();
        idle();
        @(negedge clk);
        @(negedge clk);
        last = 1;
        stall[0] = 0;
        stall[1] = 0;
        for (int k = 0; k < 500; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (!stall[n]) begin
                    int kind;
                    kind = $urandom_range(0, 9);
                    rq_r[n]  = (kind <= 3) || (kind == 6);
                    rq_w[n]  = (kind == 4) || (kind == 5) || (kind == 6);
                    rq_a[n]  = 'h40 + $urandom_range(0, 15);
                    rq_be[n] = 4'($urandom_range(0, 15));
                    rq_d[n]  = $urandom;
                end
            end
            if (k >= 490) begin
                rq_r[0] = 0; rq_w[0] = 0; rq_r[1] = 0; rq_w[1] = 0;
            end
            drive(rq_r[0], rq_w[0], rq_a[0], rq_be[0], rq_d[0],
                  rq_r[1], rq_w[1], rq_a[1], rq_be[1], rq_d[1]);
            #1;
            e0 = rq_r[0] | rq_w[0];
            e1 = rq_r[1] | rq_w[1];
            if (e0 && e1) g = (last == 0) ? 1 : 0;
            else if (e0)  g = 0;
            else if (e1)  g = 1;
            else          g = -1;
            chk("rnd_wait0", m0_waitrequest, e0 && g != 0);
            chk("rnd_wait1", m1_waitrequest, e1 && g != 1);
            chk("rnd_cs", s_chipselect, g >= 0);
            chk("rnd_sw", s_write, g >= 0 && rq_w[g]);
            if (g >= 0) begin
                chk("rnd_addr", s_address, rq_a[g]);
                chk("rnd_be", s_byteenable, rq_be[g]);
                if (rq_w[g]) chk("rnd_wd", s_writedata, rq_d[g]);
            end
            if (q.size() > 0 && q[0].due == k) begin
                chk("rnd_rdv0", m0_readdatavalid, q[0].id == 0);
                chk("rnd_rdv1", m1_readdatavalid, q[0].id == 1);
                chk("rnd_data", m0_readdata, q[0].data);
                void'(q.pop_front());
            end else begin
                chk("rnd_rdv0", m0_readdatavalid, 0);
                chk("rnd_rdv1", m1_readdatavalid, 0);
            end
            if (g >= 0) begin
                if (rq_w[g]) sh_write(rq_a[g], rq_be[g], rq_d[g]);
                else q.push_back('{k + RD_LAT, g, shadow[rq_a[g]]});
                last = g;
            end
            stall[0] = e0 && g != 0;
            stall[1] = e1 && g != 1;
            @(negedge clk);
        end
        chk("rnd_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core6_mem_arbiter.md
# core6_mem_arbiter

Two-master Avalon-MM arbiter that sits directly upstream of a single-port on-chip memory (13-bit word address, 32-bit data, 4 byte enables, unregistered output, 1-cycle read latency). It lets two processor data masters share one memory slave port. It grants access round-robin, stalls the loser with `waitrequest`, and returns read data with a per-master `readdatavalid` tagged through a latency pipeline. The slave-side outputs drive the memory's `address`/`byteenable`/`chipselect`/`write`/`writedata`/`clken` inputs directly.

## Interface
- `ADDR_W`, 13, word address width
- `DATA_W`, 32, data width
- `BE_W`, 4, byte-enable width (`DATA_W`/8)
- `RD_LAT`, 1, memory read latency in cycles; legal values are 1 and 2
- `clk`  in  1  single clock
- `reset_n`  in  1  asynchronous, active-low reset
- `mN_address`  in  `ADDR_W`  master N word address (N = 0, 1, for all `mN_` ports)
- `mN_byteenable`  in  `BE_W`  master N byte enables
- `mN_read`  in  1  master N read request
- `mN_write`  in  1  master N write request
- `mN_writedata`  in  `DATA_W`  master N write data
- `mN_lock`  in  1  master N lock request; present only with `CORE6_ARB_LOCK_EN`
- `mN_waitrequest`  out  1  stall to master N
- `mN_readdata`  out  `DATA_W`  read data, shared by both masters
- `mN_readdatavalid`  out  1  read data valid for master N
- `s_address`  out  `ADDR_W`  to memory
- `s_byteenable`  out  `BE_W`  to memory
- `s_chipselect`  out  1  to memory
- `s_write`  out  1  to memory
- `s_writedata`  out  `DATA_W`  to memory
- `s_clken`  out  1  to memory; tied to 1
- `s_readdata`  in  `DATA_W`  from memory

## Operation
- **Request:** `reqN = mN_read | mN_write`.
- **Grant:** combinational, at most one master per cycle.
  - Exactly one master requesting: that master is granted.
  - Both masters requesting: the master that is not `last_grant` is granted.
- **Fairness state:** `last_grant` is a 1-bit register, updated to the granted master's index on every granted cycle.
- **Slave-side mux:** the granted master's address, byteenable and writedata drive the `s_*` outputs.
  - `s_chipselect` = any grant.
  - `s_write` = the granted master's `mN_write`.
  - With no grant, `s_chipselect`=0, `s_write`=0, and the other `s_*` outputs are don't-care.
- **Stall:** `mN_waitrequest` = `reqN & ~grantN`. A master with no request sees `waitrequest`=0.
- **Read and write asserted together:** treated as a write; the read is discarded and no `readdatavalid` is produced.
- **Read tracking:** a granted read pushes {valid=1, id=N} into an `RD_LAT`-deep shift pipe.
  - At the pipe tail, `mN_readdatavalid` = `tail.valid & (tail.id == N)`.
  - `mN_readdata` = `s_readdata` for both masters.
- **Pipelining:** back-to-back reads are fully pipelined, one per cycle, in any master mix.

## Timing
- **Reset values** (while `reset_n`=0): `last_grant`=1, so master 0 wins the first contention.
  - Pipe valid bits = 0.
  - All grants are forced to 0, so `waitrequest`=1 for any requesting master.
  - `s_chipselect`=0, `s_write`=0, both `readdatavalid`=0.
- **Reset mid-operation:** reads in flight are dropped; no `readdatavalid` follows reset deassertion.
- **Write latency:** a write completes in the cycle it is granted.
- **Read latency:** `readdatavalid` rises exactly `RD_LAT` cycles after the grant cycle.
- **Throughput under contention:** grants strictly alternate 0,1,0,1…, giving 50% bandwidth to each master.
- **Lone requester:** receives a grant every cycle.
- **Lost arbitration:** a master that loses holds its request per Avalon rules and is guaranteed the grant in the next cycle, unless lock applies.

## Configuration
- **`CORE6_ARB_LOCK_EN` defined:** adds `mN_lock` ports and an `owner` register (valid + id, reset to invalid).
  - A granted transaction with `mN_lock`=1 sets `owner`=N.
  - While `owner` is valid, only the owner can be granted; the other master sees `waitrequest`=1.
  - The owner's first granted transaction with `mN_lock`=0 completes and clears `owner`.
  - Arbitration with no owner is unchanged.
- **Undefined:** no lock ports and no `owner` logic; behaviour is pure round-robin.

## Test plan
- **Reset state:** hold `reset_n`=0 with `m0_read`=1 → `m0_waitrequest`=1, `s_chipselect`=0. Release reset → first-cycle grant to m0.
- **Lone read:** m0 reads address 0x0005 where memory holds 0xDEADBEEF, `RD_LAT`=1 → `m0_readdatavalid`=1 one cycle later with data 0xDEADBEEF; `m1_readdatavalid` stays 0.
- **Contention:** both masters read continuously for 6 cycles → grants go 0,1,0,1,0,1; the `readdatavalid` pulses follow the same order, lagging by `RD_LAT`.
- **Byte write, then read:** m1 writes 0x000000AA with `byteenable`=0001 to 0x1FFF, then reads it back → the low byte reads 0xAA and the upper bytes are unchanged; `s_address`=0x1FFF.
- **Mid-read reset:** assert `reset_n`=0 in the cycle after an m0 read grant → no `readdatavalid` follows; `last_grant` is back to 1.
- **Lock (`CORE6_ARB_LOCK_EN`):** m0 reads with `lock`=1, then writes with `lock`=0, while m1 requests throughout → m1 is stalled for both m0 transactions and granted in the cycle after the unlock write.
